uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
- Transmit framing FSM for the UART-Tx path.
- Sits directly downstream of the baud timer: it consumes the timer's one-cycle baud tick and shifts out a serial frame (start, data LSB-first, optional parity, 1 or 2 stop bits) on TxOut.
- Drives the timer's enable and accepts parallel bytes from the host via a Send/Busy handshake.

Parameters:
- DataBits, 8, number of data bits per frame; legal range 5..9.
- CountBits, 4, width of the internal bit counter; must satisfy 2^CountBits > DataBits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- DataIn  input  DataBits  byte to transmit; sampled only when a Send is accepted.
- Send  input  1  transmit request; level-sampled.
- ParityType  input  2  00 none, 01 odd, 10 even, 11 none; sampled with DataIn.
- StopBits  input  1  0 = one stop bit, 1 = two stop bits; sampled with DataIn.
- BaudTick  input  1  one-cycle pulse from the baud timer marking the end of a bit period.
- TimerEnable  output  1  enable to the baud timer; high whenever a frame is in progress.
- TxOut  output  1  serial line; idles high.
- Busy  output  1  high from frame acceptance until the end of the last stop bit.
- Done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- All outputs are registered.
- Reset values: TxOut=1, Busy=0, Done=0, TimerEnable=0, state IDLE, bit counter 0, shift and latch registers 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TxOut=1.
  - BaudTick is ignored.
  - If Send=1 at an edge, that same edge latches DataIn, ParityType and StopBits, and computes the parity bit from DataIn:
    - even: XOR of all bits;
    - odd: inverted XOR.
  - The same edge also sets state=START, TxOut=0, Busy=1, TimerEnable=1.
- START: on an edge with BaudTick=1, go to DATA and drive TxOut = data bit0; counter=0.
- DATA:
  - On each BaudTick edge, shift right and increment the counter.
  - While counter < DataBits-1, drive the next bit.
  - When counter = DataBits-1:
    - if parity is enabled, go to PARITY and drive TxOut = parity bit;
    - otherwise go to STOP and drive TxOut=1.
- PARITY: on a BaudTick edge, go to STOP with TxOut=1 and stop counter=0.
- STOP:
  - On a BaudTick edge:
    - if StopBits latch=1 and stop counter=0, increment the stop counter and stay in STOP;
    - otherwise go to IDLE with Busy=0, TimerEnable=0, Done=1 for exactly one cycle, TxOut=1.
- Line timing: each TxOut bit is held from the tick edge that started it to the next tick edge. The latency from Send acceptance to the falling start edge is 1 cycle (the accepting edge).
- Busy/Send:
  - Send while Busy=1 is ignored; no queuing, and the latched data is unchanged.
  - Send may be held high continuously: a new frame is accepted on the first edge where the FSM is in IDLE, i.e. the cycle Done is high. Back-to-back frames therefore have no idle gap beyond that one cycle.
- Sampling rules:
  - DataIn, ParityType and StopBits changing mid-frame have no effect.
  - BaudTick is sampled only in non-IDLE states.
- Reset asserted mid-frame: outputs return to reset values asynchronously, so TxOut goes high immediately, aborting the frame. No Done pulse is produced.
- DataBits=9 with parity gives a 12- or 13-bit frame. The counter must not wrap.

Test Plan:
- Reset, then idle 20 cycles with BaudTick pulsing every 4 cycles -> TxOut=1, Busy=0, Done=0, TimerEnable=0 throughout.
- DataIn=0xA5, ParityType=10, StopBits=0, single Send pulse, tick every 4 cycles -> TxOut sequence per bit period is 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop). Done pulses once after the stop-bit tick; Busy is high for exactly 11 bit periods.
- DataIn=0x01, ParityType=01, StopBits=1 -> parity bit 0, two stop bits (line high for 2 periods before Done); 12 periods total.
- ParityType=00, DataIn=0xFF, Send held high for two frames -> second start bit begins on the edge after Done, with no extra idle period. Each frame is 10 periods.
- Send pulsed again mid-frame with DataIn=0x3C during the first frame of 0x5A -> transmitted data remains 0x5A; no second frame starts.
- Reset asserted during the DATA state -> TxOut=1 and Busy=0 immediately (before the next clk edge). After reset releases, the next Send transmits a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// Host/timer-side bundle for the UART-Tx framer.
// The master side drives requests and the baud tick; the slave side is the framer itself.
interface uart_tx_frame_if #(
    parameter int DataBits = 8
);
    logic [DataBits-1:0] dataIn_i;
    logic                send_i;
    logic [1:0]          parityType_i;
    logic                stopBits_i;
    logic                baudTick_i;
    logic                timerEnable_o;
    logic                txOut_o;
    logic                busy_o;
    logic                done_o;

    modport master (
        output dataIn_i,
        output send_i,
        output parityType_i,
        output stopBits_i,
        output baudTick_i,
        input  timerEnable_o,
        input  txOut_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  dataIn_i,
        input  send_i,
        input  parityType_i,
        input  stopBits_i,
        input  baudTick_i,
        output timerEnable_o,
        output txOut_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framing FSM: start bit, LSB-first data, optional parity, one or two stop bits.
// Each bit period ends on a baud tick; every output is registered.
module uart_tx_frame #(
    parameter int DataBits  = 8,
    parameter int CountBits = 4
) (
    input logic            clk,
    input logic            rst,
    uart_tx_frame_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q,    state_d;
    logic [CountBits-1:0]  counter_q,  counter_d;
    logic                  stopCnt_q,  stopCnt_d;
    logic [DataBits-1:0]   shift_q,    shift_d;
    logic                  parity_q,   parity_d;
    logic                  parityEn_q, parityEn_d;
    logic                  twoStop_q,  twoStop_d;
    logic                  txOut_q,    txOut_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  timerEn_q,  timerEn_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            stopCnt_q  <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            parityEn_q <= 1'b0;
            twoStop_q  <= 1'b0;
            txOut_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timerEn_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            stopCnt_q  <= stopCnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            parityEn_q <= parityEn_d;
            twoStop_q  <= twoStop_d;
            txOut_q    <= txOut_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timerEn_q  <= timerEn_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        stopCnt_d  = stopCnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        parityEn_d = parityEn_q;
        twoStop_d  = twoStop_q;
        txOut_d    = txOut_q;
        busy_d     = busy_q;
        timerEn_d  = timerEn_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                txOut_d = 1'b1;
                if (bus.send_i) begin
                    shift_d    = bus.dataIn_i;
                    parityEn_d = (bus.parityType_i == 2'b01) || (bus.parityType_i == 2'b10);
                    parity_d   = (bus.parityType_i == 2'b01) ? ~^bus.dataIn_i : ^bus.dataIn_i;
                    twoStop_d  = bus.stopBits_i;
                    counter_d  = '0;
                    stopCnt_d  = 1'b0;
                    state_d    = START;
                    txOut_d    = 1'b0;
                    busy_d     = 1'b1;
                    timerEn_d  = 1'b1;
                end
            end

            START: begin
                if (bus.baudTick_i) begin
                    state_d   = DATA;
                    txOut_d   = shift_q[0];
                    counter_d = '0;
                end
            end

            // Counter holds the index of the data bit currently on the line.
            DATA: begin
                if (bus.baudTick_i) begin
                    shift_d   = shift_q >> 1;
                    counter_d = counter_q + 1'b1;
                    if (counter_q == CountBits'(DataBits - 1)) begin
                        if (parityEn_q) begin
                            state_d = PARITY;
                            txOut_d = parity_q;
                        end else begin
                            state_d   = STOP;
                            txOut_d   = 1'b1;
                            stopCnt_d = 1'b0;
                        end
                    end else begin
                        txOut_d = shift_q[1];
                    end
                end
            end

            PARITY: begin
                if (bus.baudTick_i) begin
                    state_d   = STOP;
                    txOut_d   = 1'b1;
                    stopCnt_d = 1'b0;
                end
            end

            STOP: begin
                if (bus.baudTick_i) begin
                    if (twoStop_q && !stopCnt_q) begin
                        stopCnt_d = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        timerEn_d = 1'b0;
                        done_d    = 1'b1;
                        txOut_d   = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                txOut_d   = 1'b1;
                busy_d    = 1'b0;
                timerEn_d = 1'b0;
            end
        endcase
    end

    assign bus.txOut_o       = txOut_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.timerEnable_o = timerEn_q;

endmodule
